// File: rtl/proc_mem_loader_pkg.sv
// Shared types and constants for the processor memory loader.
package proc_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/proc_mem_loader_addr_gen.sv
// Word address generator: latched base, word index, last-word flag.
// Shared by the load pass and the optional read-back pass.
module proc_mem_loader_addr_gen
  import proc_mem_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [31:0]      base_i,
  input  logic [CNT_W-1:0] num_words_i,
  output logic [31:0]      addr_o,
  output logic             last_o
);

  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    num_d  = num_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      num_d  = num_words_i;
      idx_d  = '0;
    end else if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q <= '0;
      num_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      num_q  <= num_d;
      idx_q  <= idx_d;
    end
  end

  // 32-bit sum wraps naturally past the top of the address space.
  assign addr_o = base_q + (32'(idx_q) << 2);
  assign last_o = (idx_q == (num_q - CNT_W'(1)));

endmodule

// File: rtl/proc_mem_loader.sv
// Streams words into data memory while holding the processor in reset.
// Define PROC_MEM_LOADER_VERIFY_EN to add a read-back checksum pass (VERIFY).
//   state  | meaning
//   IDLE   | waiting for start, processor held in reset
//   LOAD   | accepting stream words, one write per handshake
//   VERIFY | reading back each word, summing for comparison
//   DONE   | load finished, processor released
module proc_mem_loader
  import proc_mem_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  input  logic [31:0]      in_data_i,
  output logic             memreq_val_o,
  output logic             memreq_type_o,
  output logic [31:0]      memreq_addr_o,
  output logic [31:0]      memreq_wdata_o,
  input  logic [31:0]      memresp_rdata_i,
  output logic             proc_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      checksum_o
);

  state_e      state_q, state_d;
  logic [31:0] checksum_q, checksum_d;
  logic        ag_load, ag_clr, ag_inc;
  logic [31:0] ag_addr;
  logic        ag_last;

`ifdef PROC_MEM_LOADER_VERIFY_EN
  logic        err_q, err_d;
  logic [31:0] rsum_q, rsum_d;
  logic [31:0] rsum_add;
  assign rsum_add = rsum_q + memresp_rdata_i;
`else
  logic rdata_unused;
  assign rdata_unused = ^memresp_rdata_i;
`endif

  proc_mem_loader_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (ag_load),
    .clr_i       (ag_clr),
    .inc_i       (ag_inc),
    .base_i      (base_addr_i),
    .num_words_i (num_words_i),
    .addr_o      (ag_addr),
    .last_o      (ag_last)
  );

  always_comb begin
    state_d        = state_q;
    checksum_d     = checksum_q;
    in_rdy_o       = 1'b0;
    memreq_val_o   = 1'b0;
    memreq_type_o  = MEMREQ_READ;
    memreq_addr_o  = '0;
    memreq_wdata_o = '0;
    ag_load        = 1'b0;
    ag_clr         = 1'b0;
    ag_inc         = 1'b0;
`ifdef PROC_MEM_LOADER_VERIFY_EN
    err_d          = err_q;
    rsum_d         = rsum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          checksum_d = '0;
`ifdef PROC_MEM_LOADER_VERIFY_EN
          err_d      = 1'b0;
`endif
          if (num_words_i != '0) begin
            ag_load = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        in_rdy_o = 1'b1;
        if (in_val_i) begin
          memreq_val_o   = 1'b1;
          memreq_type_o  = MEMREQ_WRITE;
          memreq_addr_o  = ag_addr;
          memreq_wdata_o = in_data_i;
          checksum_d     = checksum_q + in_data_i;
          if (ag_last) begin
`ifdef PROC_MEM_LOADER_VERIFY_EN
            ag_clr  = 1'b1;
            rsum_d  = '0;
            state_d = ST_VERIFY;
`else
            state_d = ST_DONE;
`endif
          end else begin
            ag_inc = 1'b1;
          end
        end
      end
`ifdef PROC_MEM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        memreq_val_o  = 1'b1;
        memreq_type_o = MEMREQ_READ;
        memreq_addr_o = ag_addr;
        rsum_d        = rsum_add;
        if (ag_last) begin
          err_d   = (rsum_add != checksum_q);
          state_d = ST_DONE;
        end else begin
          ag_inc = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      checksum_q <= '0;
`ifdef PROC_MEM_LOADER_VERIFY_EN
      err_q      <= 1'b0;
      rsum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      checksum_q <= checksum_d;
`ifdef PROC_MEM_LOADER_VERIFY_EN
      err_q      <= err_d;
      rsum_q     <= rsum_d;
`endif
    end
  end

`ifdef PROC_MEM_LOADER_VERIFY_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign done_o     = (state_q == ST_DONE);
  assign proc_rst_o = (state_q != ST_DONE);
  assign checksum_o = checksum_q;

endmodule

// File: tb/tb_proc_mem_loader.sv
// Scoreboard bench for proc_mem_loader; expected writes/reads are queued at
// stimulus time and retired by a negedge monitor.
module tb_proc_mem_loader;

  logic        clk, rst_n, start, in_val, in_rdy;
  logic [31:0] base_addr, in_data;
  logic [15:0] num_words;
  logic        memreq_val, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata, memresp_rdata;
  logic        proc_rst, busy, done, err;
  logic [31:0] checksum;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [16];
  logic        corrupt = 1'b0;
  logic [63:0] mon_wr;
  logic [31:0] mon_rd;

`ifdef PROC_MEM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  proc_mem_loader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .num_words_i     (num_words),
    .in_val_i        (in_val),
    .in_rdy_o        (in_rdy),
    .in_data_i       (in_data),
    .memreq_val_o    (memreq_val),
    .memreq_type_o   (memreq_type),
    .memreq_addr_o   (memreq_addr),
    .memreq_wdata_o  (memreq_wdata),
    .memresp_rdata_i (memresp_rdata),
    .proc_rst_o      (proc_rst),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .checksum_o      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb memresp_rdata = mem[memreq_addr[5:2]];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (memreq_val) begin
      check("req_while_busy", {63'd0, busy}, 64'd1);
      if (memreq_type) begin
        check("write_expected", {63'd0, wr_q.size() != 0}, 64'd1);
        if (wr_q.size() != 0) begin
          mon_wr = wr_q.pop_front();
          check("write_addr_data", {memreq_addr, memreq_wdata}, mon_wr);
        end
        mem[memreq_addr[5:2]] = (corrupt && memreq_addr == 32'h204) ?
                                (memreq_wdata ^ 32'h1) : memreq_wdata;
      end else begin
        check("read_expected", {63'd0, rd_q.size() != 0}, 64'd1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          check("read_addr", {32'd0, memreq_addr}, {32'd0, mon_rd});
        end
      end
    end else begin
      check("idle_req_zero", {31'd0, memreq_type, memreq_addr}, 64'd0);
    end
    if (in_rdy) check("write_follows_val", {63'd0, memreq_val}, {63'd0, in_val});
  end

  task automatic run_load(input logic [31:0] base, input int n, input logic [31:0] seed,
                          input int gaps, input logic exp_err);
    logic [31:0] sum;
    logic [31:0] hold;
    int waited;
    sum = 32'd0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = 16'(n);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({base + 32'(4 * i), seed * 32'(i + 1)});
      if (VERIFY) rd_q.push_back(base + 32'(4 * i));
      sum = sum + seed * 32'(i + 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gaps; g++) begin
          in_val = 1'b0; start = 1'b1; num_words = 16'd0;
          @(posedge clk); #1;
        end
      end
      start = 1'b0;
      in_val = 1'b1; in_data = seed * 32'(i + 1);
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    waited = 0;
    while (!done && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    check("done_latency", 64'(waited), VERIFY ? 64'(n) : 64'd0);
    check("done", {63'd0, done}, 64'd1);
    check("proc_rst_released", {63'd0, proc_rst}, 64'd0);
    check("busy_in_done", {63'd0, busy}, 64'd0);
    check("checksum", {32'd0, checksum}, {32'd0, sum});
    check("err", {63'd0, err}, {63'd0, exp_err});
    hold = checksum;
    repeat (2) @(posedge clk);
    #1;
    check("checksum_hold", {32'd0, checksum}, {32'd0, hold});
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_val = 1'b0; in_data = '0;
    base_addr = '0; num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_proc_rst", {63'd0, proc_rst}, 64'd1);
    check("rst_checksum", {32'd0, checksum}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;

    run_load(32'h200, 3, 32'h11, 0, 1'b0);
    run_load(32'h200, 3, 32'h11, 2, 1'b0);
    run_load(32'h200, 0, 32'h11, 0, 1'b0);
    run_load(32'hFFFF_FFFC, 2, 32'hC000_0000, 0, 1'b0);

`ifdef PROC_MEM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_load(32'h200, 3, 32'h11, 0, 1'b1);
    corrupt = 1'b0;
`endif

    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h300; num_words = 16'd4;
    wr_q.push_back({32'h300, 32'h5});
    wr_q.push_back({32'h304, 32'hA});
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_val = 1'b1; in_data = 32'h5 * 32'(i + 1);
      @(posedge clk); #1;
    end
    in_val = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_memreq", {63'd0, memreq_val}, 64'd0);
    check("midrst_proc_rst", {63'd0, proc_rst}, 64'd1);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_checksum", {32'd0, checksum}, 64'd0);
    check("midrst_writes", 64'(wr_q.size()), 64'd0);
    rst_n = 1'b1;
    run_load(32'h300, 4, 32'h5, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/proc_mem_loader.md
PROC_MEM_LOADER -- requirements
Module: ProcMemLoader

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the word-count input and the internal index.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1: begin a load; sampled only in IDLE or DONE.
REQ-005 SHALL have port base_addr, input, 32: byte address of the first word; sampled with start.
REQ-006 SHALL have port num_words, input, CNT_W: number of words to load; sampled with start.
REQ-007 SHALL have ports in_val (input, 1), in_rdy (output, 1) and in_data (input, 32): the incoming word stream.
REQ-008 SHALL have ports memreq_val (output, 1), memreq_type (output, 1; 1=write, 0=read), memreq_addr (output, 32) and memreq_wdata (output, 32): the data-memory request.
REQ-009 SHALL have port memresp_rdata, input, 32: read data, valid combinationally in the same cycle as the read request.
REQ-010 SHALL have port proc_rst, output, 1: active-high hold-in-reset for the processor.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), err (output, 1) and checksum (output, 32).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, VERIFY and DONE.
REQ-013 IDLE or DONE with start=1 and num_words>0 SHALL latch base_addr and num_words, clear the index and checksum, clear err, and enter LOAD.
REQ-014 IDLE or DONE with start=1 and num_words=0 SHALL enter DONE with checksum=0 and issue no memory request.
REQ-015 LOAD SHALL hold in_rdy=1; in_rdy SHALL be 0 in all other states.
REQ-016 In LOAD, each cycle with in_val=1 SHALL issue a combinational write in the same cycle: memreq_val=1, memreq_type=1, memreq_addr=base+4*idx, memreq_wdata=in_data.
REQ-017 Each such write SHALL increment idx and add in_data to checksum modulo 2^32.
REQ-018 A cycle in LOAD with in_val=0 SHALL leave memreq_val=0 and all state unchanged.
REQ-019 The handshake at idx=num_words-1 SHALL transition to VERIFY when it is compiled in, otherwise to DONE.
REQ-020 Address arithmetic SHALL wrap modulo 2^32 without error.
REQ-021 memreq_val SHALL be 0 in IDLE and DONE; memreq_type and memreq_addr SHALL be 0 whenever memreq_val=0.
REQ-022 busy SHALL be 1 exactly in LOAD and VERIFY; start SHALL be ignored while busy=1.
REQ-023 done SHALL be 1 exactly in DONE.
REQ-024 proc_rst SHALL be 1 in IDLE, LOAD and VERIFY, and 0 in DONE.
REQ-025 checksum SHALL hold its value in DONE until the next accepted start.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, idx=0, checksum=0 and err=0.
REQ-027 During and after reset: in_rdy=0, memreq_val=0, busy=0, done=0 and proc_rst=1.
REQ-028 Reset asserted mid-LOAD or mid-VERIFY SHALL abandon the transfer with no further requests; memory contents are left as written.

Configuration
REQ-029 Macro PROC_MEM_LOADER_VERIFY_EN defined SHALL compile in the VERIFY state.
REQ-030 VERIFY SHALL issue one read per cycle (memreq_val=1, memreq_type=0) over addresses base to base+4*(num_words-1), accumulating memresp_rdata into a separate read sum.
REQ-031 On the final read, VERIFY SHALL enter DONE and set err=1 if the read sum differs from checksum.
REQ-032 With PROC_MEM_LOADER_VERIFY_EN undefined, VERIFY logic SHALL be absent and err SHALL be tied to 0.

Structure
REQ-033 Shared package ProcMemLoaderPkg SHALL hold the state enum and the constants MEMREQ_READ=0 and MEMREQ_WRITE=1.
REQ-034 One sub-module, ProcMemLoaderAddrGen, SHALL hold the latched base, the idx counter, the last-word compare and the address output, and SHALL be reused by LOAD and VERIFY.

Verification
REQ-035 base=0x200, num_words=3, stream 0x11,0x22,0x33 with no gaps -> writes to 0x200/0x204/0x208 on consecutive cycles; checksum=0x66; done=1 and proc_rst=0 the cycle after the last write.
REQ-036 Same stream with in_val low for 2 cycles between words -> no memreq during the gaps; addresses and checksum identical to REQ-035.
REQ-037 num_words=0 -> DONE next cycle; no memreq_val ever; checksum=0.
REQ-038 base=0xFFFFFFFC, 2 words -> addresses 0xFFFFFFFC then 0x00000000; err=0.
REQ-039 With VERIFY_EN, bench memory corrupts the word at 0x204 after the write -> 3 reads follow the loads; err=1 in DONE.
REQ-040 rst=0 asserted after the 2nd of 4 writes -> IDLE next cycle; memreq_val=0; proc_rst=1; a fresh start then completes normally.
